// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared encodings, FSM states and FP32 constants for the FP execute unit
package fp_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_COMPUTE,
    S_NORM,
    S_DONE
  } fp_state_e;

  localparam int          BIAS              = 127;
  localparam int          EXP_MAX           = 255;
  localparam logic [31:0] FP_INF            = 32'h7F800000;
  localparam logic [31:0] NAN_CANON_DEFAULT = 32'h7FC00000;

  function automatic logic [31:0] fp_signed_inf(input logic sign);
    return FP_INF | {sign, 31'd0};
  endfunction

endpackage

// File: rtl/fp_exec_unit_if.sv
// rtl/fp_exec_unit_if.sv - request/result bundle between the pipeline and the FP execute unit
interface fp_exec_unit_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        invalid;
  logic        overflow;

  modport master (
    output start, flush, op, a, b, rd_in,
    input  stall, done, result, rd_out, invalid, overflow
  );

  modport slave (
    input  start, flush, op, a, b, rd_in,
    output stall, done, result, rd_out, invalid, overflow
  );
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - 25-bit leading-zero counter; an all-zero input reports 25
module fp_lzc (
  input  logic [24:0] i_val,
  output logic [4:0]  o_cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (i_val[i]) o_cnt = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fp_exec_unit.sv
// rtl/fp_exec_unit.sv - fixed-latency multi-cycle FP32 add/sub/mul execute unit
// IDLE -> ALIGN -> COMPUTE -> NORM -> DONE, truncating rounding, denormals read as zero.
module fp_exec_unit
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_CANON = NAN_CANON_DEFAULT
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fp_exec_unit_if.slave bus
);

  localparam logic [7:0] EXP_ONES = 8'(EXP_MAX);

  fp_state_e r_state, w_next;
  logic      w_stall, w_done, w_accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:    begin w_next = bus.start ? S_ALIGN : S_IDLE; w_stall = bus.start; end
      S_ALIGN:   begin w_next = S_COMPUTE; w_stall = 1'b1; end
      S_COMPUTE: begin w_next = S_NORM;    w_stall = 1'b1; end
      S_NORM:    begin w_next = S_DONE;    w_stall = 1'b1; end
      S_DONE:    begin w_next = bus.start ? S_ALIGN : S_IDLE; w_stall = bus.start; w_done = 1'b1; end
      default:   w_next = S_IDLE;
    endcase
    if (bus.flush) begin
      w_next = S_IDLE;
      if (r_state == S_IDLE || r_state == S_DONE) w_stall = 1'b0;
    end
  end

  assign w_accept = (r_state == S_IDLE || r_state == S_DONE) && bus.start && !bus.flush;

  logic [31:0] r_a, r_b;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= 32'd0; r_b <= 32'd0; r_op <= 3'd0; r_rd <= 5'd0;
    end else if (w_accept) begin
      r_a <= bus.a; r_b <= bus.b; r_op <= bus.op; r_rd <= bus.rd_in;
    end
  end

  logic        w_sa, w_sb, w_sb_eff, w_is_mul, w_illegal, w_swap;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_diff;
  logic [23:0] w_ma, w_mb, w_mx, w_my, w_my_sh;
  logic [4:0]  w_sh;
  logic signed [10:0] w_mul_exp;

  assign w_sa      = r_a[31];
  assign w_sb      = r_b[31];
  assign w_ea      = r_a[30:23];
  assign w_eb      = r_b[30:23];
  assign w_a_zero  = (w_ea == 8'd0);
  assign w_b_zero  = (w_eb == 8'd0);
  assign w_a_inf   = (w_ea == EXP_ONES) && (r_a[22:0] == 23'd0);
  assign w_b_inf   = (w_eb == EXP_ONES) && (r_b[22:0] == 23'd0);
  assign w_a_nan   = (w_ea == EXP_ONES) && (r_a[22:0] != 23'd0);
  assign w_b_nan   = (w_eb == EXP_ONES) && (r_b[22:0] != 23'd0);
  assign w_ma      = w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
  assign w_mb      = w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};
  assign w_is_mul  = (r_op == OP_MUL);
  assign w_illegal = (r_op != OP_ADD) && (r_op != OP_SUB) && (r_op != OP_MUL);
  assign w_sb_eff  = w_sb ^ (r_op == OP_SUB);

  // Larger magnitude goes first so the mantissa difference is never negative.
  assign w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_ex      = w_swap ? w_eb : w_ea;
  assign w_ey      = w_swap ? w_ea : w_eb;
  assign w_mx      = w_swap ? w_mb : w_ma;
  assign w_my      = w_swap ? w_ma : w_mb;
  assign w_diff    = w_ex - w_ey;
  assign w_sh      = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];
  assign w_my_sh   = w_my >> w_sh;
  assign w_mul_exp = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - $signed(11'(BIAS));

  logic        w_spec, w_spec_inv;
  logic [31:0] w_spec_res;

  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_res = 32'd0;
    if (w_illegal) begin
      w_spec = 1'b1; w_spec_inv = 1'b1;
    end else if (w_a_nan || w_b_nan) begin
      w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = NAN_CANON;
    end else if (w_is_mul) begin
      if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
        w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = NAN_CANON;
      end else if (w_a_inf || w_b_inf) begin
        w_spec = 1'b1; w_spec_res = fp_signed_inf(w_sa ^ w_sb);
      end else if (w_a_zero || w_b_zero) begin
        w_spec = 1'b1; w_spec_res = {w_sa ^ w_sb, 31'd0};
      end
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb_eff)) begin
      w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = NAN_CANON;
    end else if (w_a_inf) begin
      w_spec = 1'b1; w_spec_res = fp_signed_inf(w_sa);
    end else if (w_b_inf) begin
      w_spec = 1'b1; w_spec_res = fp_signed_inf(w_sb_eff);
    end
  end

  logic               r_sx, r_sub_eff, r_is_mul, r_spec, r_spec_inv;
  logic signed [10:0] r_ex;
  logic [23:0]        r_mx, r_my;
  logic [31:0]        r_spec_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sx <= 1'b0; r_sub_eff <= 1'b0; r_is_mul <= 1'b0; r_spec <= 1'b0; r_spec_inv <= 1'b0;
      r_ex <= 11'sd0; r_mx <= 24'd0; r_my <= 24'd0; r_spec_res <= 32'd0;
    end else if (r_state == S_ALIGN) begin
      r_is_mul   <= w_is_mul;
      r_spec     <= w_spec;
      r_spec_inv <= w_spec_inv;
      r_spec_res <= w_spec_res;
      if (w_is_mul) begin
        r_sx <= w_sa ^ w_sb; r_ex <= w_mul_exp; r_mx <= w_ma; r_my <= w_mb; r_sub_eff <= 1'b0;
      end else begin
        r_sx      <= w_swap ? w_sb_eff : w_sa;
        r_ex      <= $signed({3'b000, w_ex});
        r_mx      <= w_mx;
        r_my      <= w_my_sh;
        r_sub_eff <= w_sa ^ w_sb_eff;
      end
    end
  end

  logic [24:0] w_sum;
  logic [47:0] w_prod, r_prod;

  assign w_sum  = r_sub_eff ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
  assign w_prod = {24'd0, r_mx} * {24'd0, r_my};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_prod <= 48'd0;
    else if (r_state == S_COMPUTE) r_prod <= r_is_mul ? w_prod : {23'd0, w_sum};
  end

  // Add/sub and mul share one normaliser: the top 25 product bits line up with the sum.
  logic [24:0]        w_norm_in, w_shifted;
  logic [4:0]         w_lz;
  logic signed [10:0] w_exp;
  logic [22:0]        w_mant;

  assign w_norm_in = r_is_mul ? r_prod[47:23] : r_prod[24:0];

  fp_lzc u_lzc (
    .i_val (w_norm_in),
    .o_cnt (w_lz)
  );

  assign w_shifted = w_norm_in << w_lz;
  assign w_mant    = 23'(w_shifted >> 1);
  assign w_exp     = r_ex + 11'sd1 - $signed({6'd0, w_lz});

  logic [31:0] w_res;
  logic        w_inv, w_ovf;

  always_comb begin
    w_res = 32'd0;
    w_inv = 1'b0;
    w_ovf = 1'b0;
    if (r_spec) begin
      w_res = r_spec_res; w_inv = r_spec_inv;
    end else if (w_norm_in == 25'd0) begin
      w_res = 32'd0;
    end else if (w_exp >= $signed(11'(EXP_MAX))) begin
      w_res = fp_signed_inf(r_sx); w_ovf = 1'b1;
    end else if (w_exp <= 11'sd0) begin
      w_res = {r_sx, 31'd0};
    end else begin
      w_res = {r_sx, w_exp[7:0], w_mant};
    end
  end

  logic [31:0] r_result;
  logic [4:0]  r_rd_out;
  logic        r_invalid, r_overflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= 32'd0; r_rd_out <= 5'd0; r_invalid <= 1'b0; r_overflow <= 1'b0;
    end else if (r_state == S_NORM && !bus.flush) begin
      r_result <= w_res; r_rd_out <= r_rd; r_invalid <= w_inv; r_overflow <= w_ovf;
    end
  end

  assign bus.stall    = w_stall;
  assign bus.done     = w_done;
  assign bus.result   = r_result;
  assign bus.rd_out   = r_rd_out;
  assign bus.invalid  = r_invalid;
  assign bus.overflow = r_overflow;

endmodule

// File: doc/fp_exec_unit.md
FP_EXEC_UNIT -- requirements
Module: fp_exec_unit

Interface
REQ-001 Parameter: NAN_CANON, 32'h7FC00000, canonical quiet-NaN result pattern.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  execute-stage FP ALU request (FPAluE from the ID/EX register).
REQ-005 flush  in  1  synchronous abort from the hazard unit (same cycle as ID/EX clr).
REQ-006 op  in  3  operation code from ALUControlE: 000 add, 001 sub, 010 mul; others illegal.
REQ-007 a, b  in  32 each  IEEE-754 single-precision operands (forwarded RD1E/RD2E).
REQ-008 rd_in  in  5  destination register tag (RdE).
REQ-009 stall  out  1  holds the IF/ID and ID/EX registers while the unit is occupied.
REQ-010 done  out  1  one-cycle pulse marking result and flags valid.
REQ-011 result  out  32  FP32 result, valid only while done=1.
REQ-012 rd_out  out  5  tag captured at start, valid while done=1.
REQ-013 invalid, overflow  out  1 each  exception flags, valid while done=1.

Function
REQ-014 The FSM SHALL have states IDLE, ALIGN, COMPUTE, NORM, DONE.
- IDLE->ALIGN on start.
- ALIGN->COMPUTE->NORM->DONE unconditionally.
- DONE->ALIGN if start, else IDLE.
REQ-015 start SHALL be ignored in ALIGN, COMPUTE and NORM.
REQ-016 a, b, op and rd_in SHALL be registered on the edge that accepts start. They SHALL NOT be sampled again for that operation.
REQ-017 Latency SHALL be fixed. For start accepted at edge k, done=1 for exactly the cycle after edge k+3 and is 0 otherwise.
REQ-018 stall SHALL be combinational: 1 when the state is ALIGN/COMPUTE/NORM, or the state is IDLE/DONE with start=1 and flush=0; else 0.
REQ-019 flush SHALL take priority over start and over every state. It returns the FSM to IDLE at the next edge with no done pulse, and it does not accept a start asserted in the same cycle.
REQ-020 ALIGN SHALL perform the following.
- Unpack sign, exponent and mantissa with hidden bit.
- Treat exponent 0 (denormal) operands as signed zero.
- For add/sub, swap operands so the larger magnitude comes first, and right-shift the smaller mantissa by the exponent difference, saturating at 26.
- Invert the sign of b for sub.
REQ-021 COMPUTE SHALL produce a 25-bit signed-magnitude mantissa sum/difference for add/sub. For mul it SHALL produce a 48-bit product with exponent ea+eb-127.
REQ-022 NORM SHALL use a leading-zero count to normalise the mantissa to a 1.23 format and adjust the exponent. Rounding SHALL be truncation (round toward zero).
REQ-023 Special cases SHALL override the arithmetic result:
- Any NaN operand, inf-inf (effective subtraction), or inf*0 gives NAN_CANON with invalid=1.
- Any other infinity gives the correctly signed infinity.
- An exact zero sum gives +0.
- Biased exponent >=255 gives signed infinity (0x7F800000|sign) with overflow=1.
- Biased exponent <=0 gives signed zero, with no flag.
REQ-024 An illegal op SHALL follow the same latency, with result 32'h0 and invalid=1.
REQ-025 result, rd_out and the flags SHALL hold their values from DONE until the next DONE. They are not cleared in IDLE.

Reset
REQ-026 While reset=0, the unit SHALL be in state IDLE with done=0, result=0, rd_out=0, invalid=0, overflow=0 and all internal operand registers 0. stall SHALL then equal start.
REQ-027 Reset asserted mid-operation SHALL abandon the operation immediately, with no done pulse after reset is released.

Structure
REQ-028 Shared package fp_pkg SHALL hold:
- the op encodings;
- the FSM state enum;
- the constants BIAS=127, EXP_MAX=255, FP_INF=32'h7F800000 and the NAN_CANON default.
REQ-029 A sub-module fp_lzc SHALL provide a 25-bit leading-zero count (5-bit output) used in NORM. All other logic SHALL reside in fp_exec_unit.

Verification
REQ-030 Add 1.0+2.0: start, op=000, a=0x3F800000, b=0x40000000 -> done 4 cycles later, result=0x40400000, flags 0, rd_out equal to rd_in; stall=1 for 4 cycles.
REQ-031 Sub and mul back-to-back:
- 1.0-1.0 (op=001, a=b=0x3F800000) -> result=0x00000000.
- start held in DONE, then 1.5*2.0 (op=010, 0x3FC00000, 0x40000000) -> result=0x40400000 exactly 4 cycles after the first done.
REQ-032 Specials:
- inf-inf (0x7F800000 sub 0x7F800000) -> 0x7FC00000 with invalid=1.
- 0x7F7FFFFF*0x40000000 -> 0x7F800000 with overflow=1.
- op=111 -> 0x0 with invalid=1.
REQ-033 Flush in the COMPUTE cycle -> no done, FSM in IDLE at the next edge, stall=0; a start in the following cycle completes normally.
REQ-034 reset=0 pulsed during NORM -> outputs at their reset values immediately, and no done pulse within 8 cycles after release.
